// File: rtl/memory_access_stage.sv
// MEM pipeline stage: issues one bus read/write per load/store, stalls the front of the
// pipeline until the bus completes, and formats load data into the register-file width.
module memory_access_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic        memory_to_register_memory,
  input  logic        memory_write_memory,
  input  logic [5:0]  op_memory,
  input  logic [31:0] ALU_output_memory,
  input  logic [31:0] write_data_memory,
  output logic [31:0] data_address,
  output logic        data_read,
  output logic        data_write,
  output logic [3:0]  data_byteenable,
  output logic [31:0] data_writedata,
  input  logic [31:0] data_readdata,
  input  logic        data_waitrequest,
  output logic [31:0] read_data_memory,
  output logic        stall_memory,
  output logic        address_error
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned OP_W   = 6;

  localparam logic [OP_W-1:0] OP_LB  = 6'h20;
  localparam logic [OP_W-1:0] OP_LH  = 6'h21;
  localparam logic [OP_W-1:0] OP_LWL = 6'h22;
  localparam logic [OP_W-1:0] OP_LW  = 6'h23;
  localparam logic [OP_W-1:0] OP_LBU = 6'h24;
  localparam logic [OP_W-1:0] OP_LHU = 6'h25;
  localparam logic [OP_W-1:0] OP_LWR = 6'h26;
  localparam logic [OP_W-1:0] OP_SB  = 6'h28;
  localparam logic [OP_W-1:0] OP_SH  = 6'h29;
  localparam logic [OP_W-1:0] OP_SW  = 6'h2B;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t state, state_next;

  logic              access, misaligned, addr_err, mem_op;
  logic              fsm_req, fsm_stall, capture, complete;
  logic              in_busy;

  logic              cap_load;
  logic [OP_W-1:0]   cap_op;
  logic [DATA_W-1:0] cap_addr, cap_rt;

  logic              cur_load;
  logic [OP_W-1:0]   cur_op;
  logic [DATA_W-1:0] cur_addr, cur_rt;
  logic [4:0]        lane_shift, lwl_shift;

  logic [3:0]        be_fmt;
  logic [DATA_W-1:0] wd_fmt;
  logic [7:0]        lane_byte;
  logic [15:0]       lane_half;
  logic [DATA_W-1:0] lwl_mask, lwr_mask;
  logic [DATA_W-1:0] load_fmt;

  // Alignment check on the live instruction; misaligned accesses never reach the bus
  always_comb begin : addr_check
    misaligned = 1'b0;
    case (op_memory)
      OP_LW, OP_SW:         misaligned = |ALU_output_memory[1:0];
      OP_LH, OP_LHU, OP_SH: misaligned = ALU_output_memory[0];
      default:              misaligned = 1'b0;
    endcase
  end

  assign access   = memory_to_register_memory | memory_write_memory;
  assign addr_err = access & misaligned;
  assign mem_op   = access & ~addr_err;

  // While waiting on the bus, drive from the values captured at issue
  assign in_busy  = (state == BUSY);
  assign cur_load = in_busy ? cap_load : memory_to_register_memory;
  assign cur_op   = in_busy ? cap_op   : op_memory;
  assign cur_addr = in_busy ? cap_addr : ALU_output_memory;
  assign cur_rt   = in_busy ? cap_rt   : write_data_memory;

  assign lane_shift = {cur_addr[1:0], 3'b000};
  assign lwl_shift  = 5'(5'd24 - lane_shift);

  always_comb begin : store_format
    be_fmt = 4'b1111;
    wd_fmt = cur_rt;
    if (!cur_load) begin
      case (cur_op)
        OP_SB: begin
          be_fmt = 4'(4'b0001 << cur_addr[1:0]);
          wd_fmt = {4{cur_rt[7:0]}};
        end
        OP_SH: begin
          be_fmt = cur_addr[1] ? 4'b1100 : 4'b0011;
          wd_fmt = {2{cur_rt[15:0]}};
        end
        default: begin
          be_fmt = 4'b1111;
          wd_fmt = cur_rt;
        end
      endcase
    end
  end

  assign lane_byte = 8'(data_readdata >> lane_shift);
  assign lane_half = 16'(data_readdata >> lane_shift);
  assign lwl_mask  = (32'd1 << lwl_shift) - 32'd1;
  assign lwr_mask  = ~(32'hFFFF_FFFF >> lane_shift);

  // LWL/LWR merge the bus word with the untouched bytes of rt
  always_comb begin : load_format
    load_fmt = data_readdata;
    case (cur_op)
      OP_LB:   load_fmt = {{24{lane_byte[7]}}, lane_byte};
      OP_LBU:  load_fmt = {24'h000000, lane_byte};
      OP_LH:   load_fmt = {{16{lane_half[15]}}, lane_half};
      OP_LHU:  load_fmt = {16'h0000, lane_half};
      OP_LWL:  load_fmt = (data_readdata << lwl_shift) | (cur_rt & lwl_mask);
      OP_LWR:  load_fmt = (data_readdata >> lane_shift) | (cur_rt & lwr_mask);
      default: load_fmt = data_readdata;
    endcase
  end

  always_comb begin : fsm_next
    state_next = state;
    fsm_req    = 1'b0;
    fsm_stall  = 1'b0;
    capture    = 1'b0;
    case (state)
      IDLE: begin
        if (mem_op) begin
          fsm_req    = 1'b1;
          fsm_stall  = 1'b1;
          capture    = 1'b1;
          state_next = data_waitrequest ? BUSY : DONE;
        end
      end
      BUSY: begin
        fsm_req   = 1'b1;
        fsm_stall = 1'b1;
        if (!data_waitrequest) state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign complete = fsm_req & ~data_waitrequest;

  always_ff @(posedge clk or posedge reset) begin : state_reg
    if (reset) begin
      state            <= IDLE;
      cap_load         <= 1'b0;
      cap_op           <= '0;
      cap_addr         <= '0;
      cap_rt           <= '0;
      read_data_memory <= '0;
    end else begin
      state <= state_next;
      if (capture) begin
        cap_load <= memory_to_register_memory;
        cap_op   <= op_memory;
        cap_addr <= ALU_output_memory;
        cap_rt   <= write_data_memory;
      end
      if (complete && cur_load) read_data_memory <= load_fmt;
    end
  end

  // Bus and pipeline-control outputs are forced low for the whole reset pulse
  assign data_read       = ~reset & fsm_req & cur_load;
  assign data_write      = ~reset & fsm_req & ~cur_load;
  assign stall_memory    = ~reset & fsm_stall;
  assign address_error   = ~reset & addr_err;
  assign data_byteenable = (reset | ~fsm_req) ? 4'b0000 : be_fmt;
  assign data_address    = reset ? '0 : {cur_addr[31:2], 2'b00};
  assign data_writedata  = reset ? '0 : wd_fmt;

endmodule

// File: tb/tb_memory_access_stage.sv
// Bench for memory_access_stage: directed cases with literal expectations plus a
// randomized run compared every cycle against a byte-level behavioural model.
module tb_memory_access_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        load, store;
  logic [5:0]  op;
  logic [31:0] alu, rt;
  logic [31:0] data_address;
  logic        data_read, data_write;
  logic [3:0]  data_byteenable;
  logic [31:0] data_writedata;
  logic [31:0] data_readdata;
  logic        data_waitrequest;
  logic [31:0] read_data_memory;
  logic        stall_memory;
  logic        address_error;

  memory_access_stage dut (
    .clk                       (clk),
    .reset                     (reset),
    .memory_to_register_memory (load),
    .memory_write_memory       (store),
    .op_memory                 (op),
    .ALU_output_memory         (alu),
    .write_data_memory         (rt),
    .data_address              (data_address),
    .data_read                 (data_read),
    .data_write                (data_write),
    .data_byteenable           (data_byteenable),
    .data_writedata            (data_writedata),
    .data_readdata             (data_readdata),
    .data_waitrequest          (data_waitrequest),
    .read_data_memory          (read_data_memory),
    .stall_memory              (stall_memory),
    .address_error             (address_error)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic bit model_err(input bit ld, input bit st, input logic [5:0] o,
                                   input logic [31:0] a);
    if (!(ld || st)) return 1'b0;
    if (o == 6'h23 || o == 6'h2B) return (a[1:0] != 2'b00);
    if (o == 6'h21 || o == 6'h25 || o == 6'h29) return a[0];
    return 1'b0;
  endfunction

  function automatic logic [31:0] model_load(input logic [5:0] o, input logic [31:0] a,
                                             input logic [31:0] m, input logic [31:0] r);
    logic [7:0]  mb [4];
    logic [7:0]  tb [4];
    logic [7:0]  rb [4];
    logic [15:0] h;
    int k;
    k = int'(a[1:0]);
    for (int i = 0; i < 4; i++) begin
      mb[i] = m[8*i +: 8];
      tb[i] = r[8*i +: 8];
    end
    case (o)
      6'h20: return {{24{mb[k][7]}}, mb[k]};
      6'h24: return {24'h0, mb[k]};
      6'h21: begin h = {mb[k+1], mb[k]}; return {{16{h[15]}}, h}; end
      6'h25: begin h = {mb[k+1], mb[k]}; return {16'h0, h}; end
      6'h22: begin
        for (int i = 0; i < 4; i++)
          if (i >= 3 - k) rb[i] = mb[i-(3-k)]; else rb[i] = tb[i];
        return {rb[3], rb[2], rb[1], rb[0]};
      end
      6'h26: begin
        for (int i = 0; i < 4; i++)
          if (i < 4 - k) rb[i] = mb[i+k]; else rb[i] = tb[i];
        return {rb[3], rb[2], rb[1], rb[0]};
      end
      default: return m;
    endcase
  endfunction

  function automatic logic [3:0] model_be(input bit ld, input logic [5:0] o, input logic [31:0] a);
    logic [3:0] be;
    int k;
    k = int'(a[1:0]);
    for (int i = 0; i < 4; i++) begin
      if (ld) be[i] = 1'b1;
      else if (o == 6'h28) be[i] = (i == k);
      else if (o == 6'h29) be[i] = (i == k) || (i == k + 1);
      else be[i] = 1'b1;
    end
    return be;
  endfunction

  function automatic logic [31:0] model_wd(input logic [5:0] o, input logic [31:0] r);
    logic [31:0] w;
    for (int i = 0; i < 4; i++) begin
      if (o == 6'h28) w[8*i +: 8] = r[7:0];
      else if (o == 6'h29) w[8*i +: 8] = (i % 2 == 0) ? r[7:0] : r[15:8];
      else w[8*i +: 8] = r[8*i +: 8];
    end
    return w;
  endfunction

  // Model state: an access outstanding on the bus, and the one-cycle release after it
  bit          m_waiting, m_release;
  logic [31:0] m_result;
  bit          m_err, m_req;

  always @(negedge clk) begin
    if (reset) begin
      m_waiting = 1'b0;
      m_release = 1'b0;
      m_result  = '0;
    end else begin
      m_err = model_err(load, store, op, alu);
      m_req = !m_release && (m_waiting || ((load || store) && !m_err));
      chk("address_error", 32'(address_error), 32'(m_err));
      chk("data_read", 32'(data_read), 32'(m_req && load));
      chk("data_write", 32'(data_write), 32'(m_req && !load));
      chk("stall_memory", 32'(stall_memory), 32'(m_req));
      chk("read_data_memory", read_data_memory, m_result);
      if (m_req) begin
        chk("data_address", data_address, {alu[31:2], 2'b00});
        chk("data_byteenable", 32'(data_byteenable), 32'(model_be(load, op, alu)));
        if (!load) chk("data_writedata", data_writedata, model_wd(op, rt));
      end
      if (m_release) m_release = 1'b0;
      else if (m_req) begin
        if (!data_waitrequest) begin
          if (load) m_result = model_load(op, alu, data_readdata, rt);
          m_waiting = 1'b0;
          m_release = 1'b1;
        end else begin
          m_waiting = 1'b1;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  logic [5:0] load_ops  [8] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h0F};
  logic [5:0] store_ops [4] = '{6'h28, 6'h29, 6'h2B, 6'h3F};

  // One directed access: issue, `waits` wait-stated cycles, completion, release cycle
  task automatic drive(input bit ld, input bit st, input logic [5:0] o, input logic [31:0] a,
                       input logic [31:0] r, input logic [31:0] m, input int waits,
                       input logic [31:0] exp_addr, input logic [3:0] exp_be,
                       input logic [31:0] exp_wd);
    load = ld; store = st; op = o; alu = a; rt = r; data_readdata = m;
    for (int i = 0; i <= waits; i++) begin
      data_waitrequest = (i < waits);
      @(negedge clk);
      chk("dir_stall", 32'(stall_memory), 32'd1);
      chk("dir_read", 32'(data_read), 32'(ld));
      chk("dir_write", 32'(data_write), 32'(st));
      chk("dir_address", data_address, exp_addr);
      chk("dir_byteenable", 32'(data_byteenable), 32'(exp_be));
      if (st) chk("dir_writedata", data_writedata, exp_wd);
      @(posedge clk); #1;
    end
    data_waitrequest = 1'b1;
    @(negedge clk);
    chk("dir_release_stall", 32'(stall_memory), 32'd0);
    chk("dir_release_req", 32'({data_read, data_write}), 32'd0);
    @(posedge clk); #1;
    load = 1'b0; store = 1'b0;
  endtask

  task automatic rand_inst();
    int kind;
    kind = $urandom_range(0, 9);
    alu  = $urandom;
    rt   = $urandom;
    if (kind < 2) begin
      load = 1'b0; store = 1'b0; op = 6'($urandom);
    end else if (kind < 6) begin
      load = 1'b1; store = 1'b0; op = load_ops[$urandom_range(0, 7)];
    end else begin
      load = 1'b0; store = 1'b1; op = store_ops[$urandom_range(0, 3)];
    end
  endtask

  bit hold;

  initial begin
    reset = 1'b1;
    load = 1'b1; store = 1'b0; op = 6'h23; alu = 32'h0000_0123; rt = 32'h5555_AAAA;
    data_readdata = 32'h0; data_waitrequest = 1'b0;
    #1;
    chk("rst_read", 32'(data_read), 32'd0);
    chk("rst_stall", 32'(stall_memory), 32'd0);
    chk("rst_address_error", 32'(address_error), 32'd0);
    chk("rst_byteenable", 32'(data_byteenable), 32'd0);
    chk("rst_address", data_address, 32'd0);
    chk("rst_writedata", data_writedata, 32'd0);
    chk("rst_read_data", read_data_memory, 32'd0);
    load = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;

    drive(1, 0, 6'h23, 32'h100, 32'h0, 32'hDEADBEEF, 0, 32'h100, 4'b1111, 32'h0);
    chk("lw_result", read_data_memory, 32'hDEADBEEF);
    drive(1, 0, 6'h20, 32'h103, 32'h0, 32'h80123456, 3, 32'h100, 4'b1111, 32'h0);
    chk("lb_result", read_data_memory, 32'hFFFFFF80);
    drive(1, 0, 6'h24, 32'h103, 32'h0, 32'h80123456, 3, 32'h100, 4'b1111, 32'h0);
    chk("lbu_result", read_data_memory, 32'h00000080);
    drive(0, 1, 6'h28, 32'h202, 32'h000000AB, 32'h0, 1, 32'h200, 4'b0100, 32'hABABABAB);
    drive(0, 1, 6'h29, 32'h202, 32'h00001234, 32'h0, 0, 32'h200, 4'b1100, 32'h12341234);
    chk("store_keeps_result", read_data_memory, 32'h00000080);
    drive(1, 0, 6'h22, 32'h301, 32'h11223344, 32'hAABBCCDD, 0, 32'h300, 4'b1111, 32'h0);
    chk("lwl_result", read_data_memory, 32'hCCDD3344);
    drive(1, 0, 6'h26, 32'h301, 32'h11223344, 32'hAABBCCDD, 2, 32'h300, 4'b1111, 32'h0);
    chk("lwr_result", read_data_memory, 32'h11AABBCC);

    // Misaligned LW: flagged, no bus cycle, no stall
    load = 1'b1; op = 6'h23; alu = 32'h102; data_waitrequest = 1'b0;
    @(negedge clk);
    chk("lw_misaligned_error", 32'(address_error), 32'd1);
    chk("lw_misaligned_read", 32'(data_read), 32'd0);
    chk("lw_misaligned_stall", 32'(stall_memory), 32'd0);
    @(posedge clk); #1;

    // Reset while waiting on the bus
    load = 1'b1; op = 6'h23; alu = 32'h400; data_waitrequest = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("busy_before_reset", 32'(stall_memory), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("midrst_read", 32'(data_read), 32'd0);
    chk("midrst_stall", 32'(stall_memory), 32'd0);
    chk("midrst_byteenable", 32'(data_byteenable), 32'd0);
    chk("midrst_read_data", read_data_memory, 32'd0);
    load = 1'b0;
    @(posedge clk);
    @(negedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    drive(1, 0, 6'h23, 32'h500, 32'h0, 32'h0BADF00D, 0, 32'h500, 4'b1111, 32'h0);
    chk("post_reset_lw", read_data_memory, 32'h0BADF00D);

    // Randomized traffic; the pipeline only advances when stall was low
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      hold = stall_memory;
      @(posedge clk); #1;
      if (!hold) rand_inst();
      data_waitrequest = ($urandom_range(0, 2) == 0);
      data_readdata    = $urandom;
    end

    load = 1'b0; store = 1'b0;
    repeat (4) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/memory_access_stage.md
MEMORY_ACCESS_STAGE -- requirements
Module: memory_access_stage

Interface
REQ-001 SHALL have these ports (name  direction  width  meaning), clock and reset first:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- memory_to_register_memory  in  1  current MEM-stage instruction is a load
- memory_write_memory  in  1  current MEM-stage instruction is a store
- op_memory  in  6  opcode of the MEM-stage instruction
- ALU_output_memory  in  32  effective byte address
- write_data_memory  in  32  rt value: store data, and merge source for LWL/LWR
- data_address  out  32  word-aligned bus address, {ALU_output_memory[31:2],2'b00}
- data_read  out  1  bus read request
- data_write  out  1  bus write request
- data_byteenable  out  4  active byte lanes
- data_writedata  out  32  lane-aligned store data
- data_readdata  in  32  bus read data, valid in the cycle the request completes
- data_waitrequest  in  1  bus not ready; the request completes in a cycle where it is low
- read_data_memory  out  32  formatted load result
- stall_memory  out  1  freeze the IF..EX/MEM stages
- address_error  out  1  misaligned access detected; no bus cycle is issued
REQ-002 SHALL treat reset as asynchronous and active-high, and SHALL use clk as its clock.

Function
REQ-003 SHALL implement FSM states IDLE, BUSY and DONE; the reset state SHALL be IDLE.
REQ-004 A memory operation SHALL be present when (memory_to_register_memory or memory_write_memory) is high and address_error is low.
REQ-005 In IDLE with a memory operation present, SHALL assert data_read (load) or data_write (store), and SHALL assert stall_memory.
- If data_waitrequest is low, the next state SHALL be DONE.
- Otherwise, the next state SHALL be BUSY.
REQ-006 In BUSY, SHALL hold the request, address, byteenable and writedata stable with stall_memory high, and SHALL go to DONE on the first cycle data_waitrequest is low.
REQ-007 In the completing cycle of a load, SHALL latch the formatted data_readdata into read_data_memory.
REQ-008 In DONE, SHALL deassert the request and stall_memory for exactly one cycle so the pipeline advances, then return to IDLE.
REQ-009 With no memory operation present in IDLE:
- data_read, data_write and stall_memory SHALL be 0.
- read_data_memory SHALL hold its last latched value.
REQ-010 address_error SHALL be combinational and SHALL be high when either holds:
- LW/SW with addr[1:0]!=0;
- LH/LHU/SH with addr[0]=1.
When address_error is high, no request SHALL be issued and stall_memory SHALL be 0.
REQ-011 Byte lanes SHALL be little-endian: byte offset k=addr[1:0] maps to data_readdata[8k+7:8k].
REQ-012 Loads (r = latched result, m = data_readdata, rt = write_data_memory):
- LB 0x20: sign-extended lane k.
- LBU 0x24: zero-extended lane k.
- LH 0x21: sign-extended halfword at lanes k+1..k.
- LHU 0x25: zero-extended halfword at lanes k+1..k.
- LW 0x23: m.
- LWL 0x22: low (3-k) bytes from rt, upper (k+1) bytes = m[8k+7:0].
- LWR 0x26: upper k bytes from rt, lower (4-k) bytes = m[31:8k].
- All loads SHALL use byteenable 4'b1111.
REQ-013 Stores:
- SB 0x28: byteenable 1<<k, writedata = rt[7:0] replicated in all 4 lanes.
- SH 0x29: byteenable 4'b0011 (k=0) or 4'b1100 (k=2), writedata = rt[15:0] in both halves.
- SW 0x2B: byteenable 4'b1111, writedata = rt.
REQ-014 An unlisted opcode with a load/store flag set SHALL perform a LW/SW-style full-word access.
REQ-015 Back-to-back memory instructions SHALL each take at least 2 cycles (issue + DONE); a new request SHALL NOT be issued in DONE.

Reset
REQ-016 On reset assertion, including mid-transaction, SHALL immediately:
- force state to IDLE;
- drive data_read, data_write, stall_memory, address_error and data_byteenable to 0;
- clear read_data_memory to 0.
REQ-017 data_address and data_writedata SHALL be 0 during reset.
REQ-018 After reset release, the first access SHALL start from IDLE without a spurious DONE cycle.

Verification
REQ-019 LW addr 0x100, waitrequest low, readdata 0xDEADBEEF -> read asserted 1 cycle with stall 1, DONE cycle stall 0, read_data_memory=0xDEADBEEF.
REQ-020 LB addr 0x103, readdata 0x80123456, waitrequest high 3 cycles -> stall high 4 cycles, request stable, result 0xFFFFFF80; LBU same -> 0x00000080.
REQ-021 SB addr 0x202, rt 0x000000AB -> data_address 0x200, byteenable 4'b0100, writedata 0xABABABAB; SH addr 0x202, rt 0x1234 -> byteenable 4'b1100.
REQ-022 LWL addr 0x301, rt 0x11223344, readdata 0xAABBCCDD -> 0xCCDD3344; LWR addr 0x301 -> 0x11AABBCC.
REQ-023 LW addr 0x102 -> address_error 1, no data_read, stall 0.
REQ-024 Reset asserted in BUSY -> request and stall drop in the same cycle, state IDLE, read_data_memory 0.
